// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// No logic; constants and one pure helper function.
// No flow control of its own.
package all_pkgs;

    localparam int WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    // Any funct3 not naming a byte or half access is handled as a word.
    function automatic acc_size_t access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage and memory.
// Single-cycle completion when dmem_ready is high with dmem_req.
// Memory stretches an access by holding dmem_ready low.
interface mem_stage_if;
    import all_pkgs::*;

    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [3:0]       dmem_be;
    logic [WIDTH-1:0] dmem_wdata;
    logic             dmem_ready;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data formatter: byte-lane shift plus sign/zero extension.
// Purely combinational, zero latency.
// No flow control.
module mem_load_align
    import all_pkgs::*;
(
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    // Extend the addressed byte/half; anything else returns the word as read.
    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            F3_H:    data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to data memory, registers MEM/WB.
// Zero-wait access completes in the issue cycle; WB outputs one cycle later.
// Stalls upstream while memory holds dmem_ready low, up to TIMEOUT_CYCLES wait cycles.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module mem_stage
    import all_pkgs::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic             clk,
    input  logic             rst,

    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic [WIDTH-1:0] mem_reg_data2,
    input  logic [4:0]       mem_rd,
    input  logic [2:0]       mem_funct3,
    input  logic             mem_reg_wr_en,
    input  logic [1:0]       mem_wb_sel,
    input  logic [WIDTH-1:0] mem_pc_plus4,
    input  logic             mem_mem_wr_en,
    input  logic             mem_mem_rd_en,

    output logic             mem_stall,

    mem_stage_if.master      dmem,

    output logic [WIDTH-1:0] wb_alu_result,
    output logic [WIDTH-1:0] wb_mem_data,
    output logic [WIDTH-1:0] wb_pc_plus4,
    output logic [4:0]       wb_rd,
    output logic             wb_reg_wr_en,
    output logic [1:0]       wb_wb_sel,
    output logic             wb_bus_err,
    output logic             wb_misalign
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t       state_q;
    mem_state_t       state_d;
    logic [7:0]       tmo_cnt_q;

    logic             access;
    logic             is_store;
    logic             is_load;
    acc_size_t        size;
    logic [1:0]       byte_off;
    logic             issue;
    logic             trap;
    logic             complete;
    logic             timeout;
    logic [WIDTH-1:0] load_data;

    assign access   = mem_mem_rd_en | mem_mem_wr_en;
    // A combined read+write request is a store; the load half is dropped.
    assign is_store = mem_mem_wr_en;
    assign is_load  = mem_mem_rd_en & ~mem_mem_wr_en;
    assign size     = access_size(mem_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;

    assign misalign = ((size == SZ_H) && mem_alu_result[0]) ||
                      ((size == SZ_W) && (mem_alu_result[1:0] != 2'b00));
    assign trap     = access & misalign;
    assign issue    = access & ~misalign;
`else
    // Misaligned low bits are simply cleared below; every access issues.
    assign trap     = 1'b0;
    assign issue    = access;
`endif

    // Effective byte offset within the word, with bits below the access size cleared.
    always_comb begin
        byte_off = 2'b00;
        case (size)
            SZ_B:    byte_off = mem_alu_result[1:0];
            SZ_H:    byte_off = {mem_alu_result[1], 1'b0};
            default: byte_off = 2'b00;
        endcase
    end

    // Request fields come straight from EX/MEM, which mem_stall freezes during WAIT.
    assign dmem.dmem_we    = is_store;
    assign dmem.dmem_addr  = {mem_alu_result[WIDTH-1:2], 2'b00};

    // Store byte enables and lane-replicated write data.
    always_comb begin
        dmem.dmem_be    = 4'b1111;
        dmem.dmem_wdata = mem_reg_data2;
        case (size)
            SZ_B: begin
                dmem.dmem_be    = 4'b0001 << byte_off;
                dmem.dmem_wdata = {4{mem_reg_data2[7:0]}};
            end
            SZ_H: begin
                dmem.dmem_be    = 4'b0011 << byte_off;
                dmem.dmem_wdata = {2{mem_reg_data2[15:0]}};
            end
            default: begin
                dmem.dmem_be    = 4'b1111;
                dmem.dmem_wdata = mem_reg_data2;
            end
        endcase
    end

    mem_load_align u_load_align (
        .rdata  (dmem.dmem_rdata),
        .addr   (byte_off),
        .funct3 (mem_funct3),
        .data   (load_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter WAIT on an unanswered issue, leave on ready or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue && !dmem.dmem_ready) state_d = WAIT;
            WAIT:    if (dmem.dmem_ready || (tmo_cnt_q == TMO_LAST)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: request, stall and the completion/timeout strobes; all quiet in reset.
    always_comb begin
        dmem.dmem_req = 1'b0;
        mem_stall     = 1'b0;
        complete      = 1'b0;
        timeout       = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        dmem.dmem_req = 1'b1;
                        complete      = dmem.dmem_ready;
                        mem_stall     = ~dmem.dmem_ready;
                    end
                end
                WAIT: begin
                    dmem.dmem_req = 1'b1;
                    complete      = dmem.dmem_ready;
                    timeout       = ~dmem.dmem_ready && (tmo_cnt_q == TMO_LAST);
                    mem_stall     = ~dmem.dmem_ready && ~timeout;
                end
                default: ;
            endcase
        end
    end

    // Wait-cycle counter: zero outside WAIT, counts unanswered WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE)) begin
            tmo_cnt_q <= 8'd0;
        end else if (!dmem.dmem_ready) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the stage result.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            wb_pc_plus4   <= '0;
            wb_rd         <= '0;
            wb_reg_wr_en  <= 1'b0;
            wb_wb_sel     <= '0;
            wb_bus_err    <= 1'b0;
            wb_misalign   <= 1'b0;
        end else if (mem_stall) begin
            wb_reg_wr_en  <= 1'b0;
            wb_bus_err    <= 1'b0;
            wb_misalign   <= 1'b0;
        end else begin
            wb_alu_result <= mem_alu_result;
            wb_mem_data   <= (is_load && complete) ? load_data : '0;
            wb_pc_plus4   <= mem_pc_plus4;
            wb_rd         <= mem_rd;
            wb_reg_wr_en  <= mem_reg_wr_en & ~timeout & ~trap;
            wb_wb_sel     <= mem_wb_sel;
            wb_bus_err    <= timeout;
            wb_misalign   <= trap;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a byte-addressed memory model.
// Each instruction is held until the expected number of stall cycles has elapsed.
// Memory latency per access is chosen by the bench, including never-ready.
module tb_mem_stage;
    import all_pkgs::*;

    localparam int TO = 4;
    localparam int NEVER = 1000;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] mem_alu_result;
    logic [WIDTH-1:0] mem_reg_data2;
    logic [4:0]       mem_rd;
    logic [2:0]       mem_funct3;
    logic             mem_reg_wr_en;
    logic [1:0]       mem_wb_sel;
    logic [WIDTH-1:0] mem_pc_plus4;
    logic             mem_mem_wr_en;
    logic             mem_mem_rd_en;
    logic             mem_stall;
    logic [WIDTH-1:0] wb_alu_result;
    logic [WIDTH-1:0] wb_mem_data;
    logic [WIDTH-1:0] wb_pc_plus4;
    logic [4:0]       wb_rd;
    logic             wb_reg_wr_en;
    logic [1:0]       wb_wb_sel;
    logic             wb_bus_err;
    logic             wb_misalign;

    mem_stage_if dmem();

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_alu_result (mem_alu_result),
        .mem_reg_data2  (mem_reg_data2),
        .mem_rd         (mem_rd),
        .mem_funct3     (mem_funct3),
        .mem_reg_wr_en  (mem_reg_wr_en),
        .mem_wb_sel     (mem_wb_sel),
        .mem_pc_plus4   (mem_pc_plus4),
        .mem_mem_wr_en  (mem_mem_wr_en),
        .mem_mem_rd_en  (mem_mem_rd_en),
        .mem_stall      (mem_stall),
        .dmem           (dmem),
        .wb_alu_result  (wb_alu_result),
        .wb_mem_data    (wb_mem_data),
        .wb_pc_plus4    (wb_pc_plus4),
        .wb_rd          (wb_rd),
        .wb_reg_wr_en   (wb_reg_wr_en),
        .wb_wb_sel      (wb_wb_sel),
        .wb_bus_err     (wb_bus_err),
        .wb_misalign    (wb_misalign)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] mem_b [0:1023];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int b;
        b = int'(a[9:2]) * 4;
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    // One instruction from entry into MEM to its WB slot.
    // lat: cycle (0 = issue cycle) at which memory answers; rst_at: cycle to pulse reset.
    task automatic run_instr(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data,
                             input bit rwe, input int lat, input int rst_at);
        bit          acc, st, ld, mis, trp, goes, berr;
        int          nbytes, off, base, done_k;
        logic [31:0] waddr, exp_wd, exp_ld, pc;
        logic [3:0]  exp_be;
        logic [7:0]  b0, b1;
        logic [4:0]  rdn;
        logic [1:0]  sel;
        acc    = rd_en || wr_en;
        st     = wr_en;
        ld     = rd_en && !wr_en;
        nbytes = size_of(f3);
        mis    = (addr % nbytes) != 0;
        trp    = TRAP && acc && mis;
        goes   = acc && !trp;
        off    = int'(addr[1:0]) - (int'(addr[1:0]) % nbytes);
        waddr  = addr - 32'(addr % 4);
        base   = int'(waddr[9:0]) + off;
        exp_be = 4'(((1 << nbytes) - 1) << off);
        if (nbytes == 1)      exp_wd = {4{data[7:0]}};
        else if (nbytes == 2) exp_wd = {2{data[15:0]}};
        else                  exp_wd = data;
        b0 = mem_b[base];
        b1 = mem_b[(base + 1) % 1024];
        case (f3)
            3'b000:  exp_ld = {{24{b0[7]}}, b0};
            3'b100:  exp_ld = {24'd0, b0};
            3'b001:  exp_ld = {{16{b1[7]}}, b1, b0};
            3'b101:  exp_ld = {16'd0, b1, b0};
            default: exp_ld = word_at(waddr);
        endcase
        berr   = goes && (lat > TO);
        done_k = !goes ? 0 : ((lat > TO) ? TO : lat);
        pc     = $urandom();
        rdn    = 5'($urandom());
        sel    = 2'($urandom());
        for (int k = 0; k <= done_k; k++) begin
            @(negedge clk);
            rst            = (k == rst_at);
            mem_alu_result = addr;
            mem_reg_data2  = data;
            mem_rd         = rdn;
            mem_funct3     = f3;
            mem_reg_wr_en  = rwe;
            mem_wb_sel     = sel;
            mem_pc_plus4   = pc;
            mem_mem_wr_en  = wr_en;
            mem_mem_rd_en  = rd_en;
            dmem.dmem_ready = goes && (k == lat);
            dmem.dmem_rdata = (goes && k == lat) ? word_at(waddr) : $urandom();
            #1;
            if (rst) begin
                check("rst_req", 32'(dmem.dmem_req), 32'd0);
                check("rst_stall", 32'(mem_stall), 32'd0);
            end else begin
                check("req", 32'(dmem.dmem_req), 32'(goes));
                check("stall", 32'(mem_stall), 32'(goes && k < done_k));
                if (goes) begin
                    check("addr", dmem.dmem_addr, waddr);
                    check("we", 32'(dmem.dmem_we), 32'(st));
                    if (st) begin
                        check("be", 32'(dmem.dmem_be), 32'(exp_be));
                        check("wdata", dmem.dmem_wdata, exp_wd);
                    end
                end
            end
            @(posedge clk);
            if (!rst && goes && st && k == lat) begin
                for (int i = 0; i < 4; i++)
                    if (exp_be[i]) mem_b[int'(waddr[9:0]) + i] = exp_wd[8*i +: 8];
            end
            #1;
            if (rst) begin
                check("rst_wb_alu", wb_alu_result, 32'd0);
                check("rst_wb_data", wb_mem_data, 32'd0);
                check("rst_wb_pc", wb_pc_plus4, 32'd0);
                check("rst_wb_misc", {21'd0, wb_rd, wb_reg_wr_en, wb_wb_sel, wb_bus_err, wb_misalign}, 32'd0);
                break;
            end
            if (k < done_k) begin
                check("bubble_wr_en", 32'(wb_reg_wr_en), 32'd0);
                check("bubble_err", 32'(wb_bus_err), 32'd0);
                check("bubble_mis", 32'(wb_misalign), 32'd0);
            end else begin
                check("wb_alu", wb_alu_result, addr);
                check("wb_pc", wb_pc_plus4, pc);
                check("wb_rd", 32'(wb_rd), 32'(rdn));
                check("wb_sel", 32'(wb_wb_sel), 32'(sel));
                check("wb_wr_en", 32'(wb_reg_wr_en), 32'(rwe && !berr && !trp));
                check("wb_bus_err", 32'(wb_bus_err), 32'(berr));
                check("wb_misalign", 32'(wb_misalign), 32'(trp));
                check("wb_mem_data", wb_mem_data, (ld && goes && !berr) ? exp_ld : 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom());
        // Reset with a load presented: nothing may issue or stall.
        @(negedge clk);
        rst = 1'b1;
        mem_alu_result = 32'h100; mem_reg_data2 = '0; mem_rd = 5'd1;
        mem_funct3 = F3_W; mem_reg_wr_en = 1'b1; mem_wb_sel = 2'd1;
        mem_pc_plus4 = 32'h4; mem_mem_wr_en = 1'b0; mem_mem_rd_en = 1'b1;
        dmem.dmem_ready = 1'b0; dmem.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", 32'(dmem.dmem_req), 32'd0);
        check("reset_stall", 32'(mem_stall), 32'd0);
        check("reset_wb", {wb_alu_result ^ wb_mem_data ^ wb_pc_plus4}, 32'd0);
        check("reset_wb_flags", {21'd0, wb_rd, wb_reg_wr_en, wb_wb_sel, wb_bus_err, wb_misalign}, 32'd0);

        // Zero-wait LW.
        {mem_b[32'h103], mem_b[32'h102], mem_b[32'h101], mem_b[32'h100]} = 32'hDEADBEEF;
        run_instr(1, 0, F3_W, 32'h100, 32'h0, 1, 0, -1);
        check("lw_zero_wait", wb_mem_data, 32'hDEADBEEF);
        // LB at 0x103 answered after three wait cycles.
        mem_b[32'h103] = 8'h80;
        run_instr(1, 0, F3_B, 32'h103, 32'h0, 1, 3, -1);
        check("lb_wait_sext", wb_mem_data, 32'hFFFFFF80);
        // SH to the upper half.
        run_instr(0, 1, F3_H, 32'h202, 32'h1234ABCD, 0, 0, -1);
        check("sh_stored", {mem_b[32'h203], mem_b[32'h202], mem_b[32'h201], mem_b[32'h200]} & 32'hFFFF0000,
              32'hABCD0000);
        // Never-ready access times out, then a plain instruction follows.
        run_instr(1, 0, F3_W, 32'h040, 32'h0, 1, NEVER, -1);
        run_instr(0, 0, F3_W, 32'h0, 32'h0, 1, 0, -1);
        // Misaligned word load.
        run_instr(1, 0, F3_W, 32'h101, 32'h0, 1, 0, -1);
        // Reset on the second wait cycle, then a non-memory instruction.
        run_instr(1, 0, F3_W, 32'h080, 32'h0, 1, NEVER, 2);
        run_instr(0, 0, F3_B, 32'h0, 32'h0, 0, 0, -1);
        // Both enables: handled as a store.
        run_instr(1, 1, F3_B, 32'h311, 32'h000000A5, 0, 1, -1);

        for (int n = 0; n < 300; n++) begin
            int kind, lat;
            logic [2:0] f3;
            kind = $urandom_range(0, 7);
            lat  = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 5);
            f3   = 3'($urandom());
            case (kind)
                0, 1:    run_instr(0, 0, f3, $urandom(), $urandom(), 1'($urandom()), 0, -1);
                2, 3, 4: run_instr(1, 0, f3, $urandom(), $urandom(), 1'($urandom()), lat, -1);
                5, 6:    run_instr(0, 1, 3'($urandom_range(0, 2)), $urandom(), $urandom(),
                                   1'($urandom()), lat, -1);
                default: run_instr(1, 1, 3'($urandom_range(0, 2)), $urandom(), $urandom(),
                                   1'($urandom()), lat, -1);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
